// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: runs one req/ack bus transaction per load/store,
// stalls the pipeline until the bus responds, and flags misaligned addresses and timeouts.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        align_err_o,
    output logic [31:0] badaddr_o,
    output logic        timeout_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} stateT;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

    stateT            state;
    logic [CNT_W-1:0] cnt;
    logic             acc;
    logic             mis;

    assign acc = mem_rd_i | mem_wr_i;
    assign mis = (addr_i[1:0] != 2'b00);

    // Gated by reset so both drop immediately when an access is aborted by reset.
    assign stall_o     = !reset && ((state == StIdle && acc && !mis) || state == StBusy);
    assign align_err_o = !reset && state == StIdle && acc && mis;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= StIdle;
            cnt           <= '0;
            bus_req_o     <= 1'b0;
            bus_we_o      <= 1'b0;
            bus_addr_o    <= '0;
            bus_wdata_o   <= '0;
            rdata_o       <= '0;
            rdata_valid_o <= 1'b0;
            timeout_o     <= 1'b0;
            badaddr_o     <= '0;
        end else begin
            rdata_valid_o <= 1'b0;
            timeout_o     <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (acc) begin
                        if (mis) begin
                            badaddr_o <= addr_i;
                        end else begin
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= mem_wr_i;
                            bus_addr_o  <= {addr_i[31:2], 2'b00};
                            bus_wdata_o <= wdata_i;
                            cnt         <= '0;
                            state       <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                        if (!bus_we_o) begin
                            rdata_o       <= bus_rdata_i;
                            rdata_valid_o <= 1'b1;
                        end
                        state <= StDone;
                    end else if (cnt == CntLast) begin
                        bus_req_o <= 1'b0;
                        badaddr_o <= bus_addr_o;
                        timeout_o <= 1'b1;
                        if (!bus_we_o) begin
                            rdata_o <= '0;
                        end
                        state <= StDone;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Inputs are ignored here so the stalled instruction is never relaunched.
                StDone: state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed accesses with a scoreboard queue of
// expected bus/result events, checked by an independent monitor process.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        mem_rd_i;
    logic        mem_wr_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        align_err_o;
    logic [31:0] badaddr_o;
    logic        timeout_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    mem_access_unit #(.TIMEOUT(4), .CNT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_rd_i     (mem_rd_i),
        .mem_wr_i     (mem_wr_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .stall_o      (stall_o),
        .rdata_o      (rdata_o),
        .rdata_valid_o(rdata_valid_o),
        .align_err_o  (align_err_o),
        .badaddr_o    (badaddr_o),
        .timeout_o    (timeout_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_ack_i    (bus_ack_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    // kind: 1 = completed read, 2 = timeout, 3 = write handshake
    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
    } expT;

    expT sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  obsKind;
    expT e;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT presents a result or a write handshake.
    initial forever begin
        @(negedge clk);
        #1;
        if (!reset) begin
            obsKind = 0;
            if (rdata_valid_o) obsKind = 1;
            else if (timeout_o) obsKind = 2;
            else if (bus_req_o && bus_ack_i && bus_we_o) obsKind = 3;
            if (obsKind != 0) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: event kind %0d with empty queue", obsKind);
                end else begin
                    e = sb.pop_front();
                    check("sb_kind", obsKind, e.kind);
                    case (e.kind)
                        1: begin
                            check("sb_rdata", rdata_o, e.d);
                            check("sb_rd_timeout", {31'b0, timeout_o}, 32'd0);
                        end
                        2: begin
                            check("sb_badaddr", badaddr_o, e.a);
                            check("sb_to_rdata", rdata_o, e.d);
                        end
                        3: begin
                            check("sb_waddr", bus_addr_o, e.a);
                            check("sb_wdata", bus_wdata_o, e.d);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Drives one aligned access from IDLE (entered at posedge+1) and returns in the next IDLE.
    task automatic access(input string name, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata, input int waitCyc,
                          input logic [31:0] busData, input logic strayAck, input int expStall,
                          input int expBusy, output int doneCyc);
        int  stalls = 0;
        int  busy = 0;
        bit  done = 0;
        expT x;
        if (wr) x = '{3, addr & 32'hFFFF_FFFC, wdata};
        else if (waitCyc < 0) x = '{2, addr, 32'h0};
        else x = '{1, 32'h0, busData};
        sb.push_back(x);
        doneCyc = 0;
        mem_rd_i = rd;
        mem_wr_i = wr;
        addr_i = addr;
        wdata_i = wdata;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (bus_req_o) begin
                busy++;
                check({name, "_bus_addr"}, bus_addr_o, addr & 32'hFFFF_FFFC);
                check({name, "_bus_we"}, {31'b0, bus_we_o}, {31'b0, wr});
                if (wr) check({name, "_bus_wdata"}, bus_wdata_o, wdata);
                bus_ack_i = (waitCyc >= 0 && busy == waitCyc + 1);
                bus_rdata_i = bus_ack_i ? busData : 32'h0BAD_0BAD;
            end else begin
                bus_ack_i = strayAck;
                bus_rdata_i = 32'h0BAD_0BAD;
            end
            if (stall_o) begin
                stalls++;
            end else if (c > 0) begin
                done = 1;
                doneCyc = cyc;
                mem_rd_i = 1'b0;
                mem_wr_i = 1'b0;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_done: no DONE within 40 cycles, stalls %0d", name, stalls);
        end
        check({name, "_stall_cycles"}, stalls, expStall);
        check({name, "_busy_cycles"}, busy, expBusy);
        @(posedge clk);
        #1;
    endtask

    int d1, d2, dx;

    initial begin
        reset = 1'b1;
        mem_rd_i = 1'b0;
        mem_wr_i = 1'b0;
        addr_i = '0;
        wdata_i = '0;
        bus_ack_i = 1'b0;
        bus_rdata_i = '0;
        #12;
        check("rst_req", {31'b0, bus_req_o}, 32'd0);
        check("rst_stall", {31'b0, stall_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_badaddr", badaddr_o, 32'd0);
        check("rst_bus_addr", bus_addr_o, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Zero-wait load.
        access("ld0", 1, 0, 32'h1000_0004, 32'h0, 0, 32'hDEAD_BEEF, 0, 2, 1, dx);
        check("ld0_rdata_hold", rdata_o, 32'hDEAD_BEEF);

        // Store, ack in 4th BUSY cycle (same cycle as the last counter value).
        access("st0", 0, 1, 32'h0000_0010, 32'h1234_5678, 3, 32'h0, 0, 5, 4, dx);
        check("st0_rdata_unchanged", rdata_o, 32'hDEAD_BEEF);

        // Misaligned load.
        mem_rd_i = 1'b1;
        addr_i = 32'h0000_0006;
        #1;
        check("mis_align_err", {31'b0, align_err_o}, 32'd1);
        check("mis_stall", {31'b0, stall_o}, 32'd0);
        @(negedge clk);
        check("mis_no_req", {31'b0, bus_req_o}, 32'd0);
        @(posedge clk);
        #1;
        mem_rd_i = 1'b0;
        #1;
        check("mis_badaddr", badaddr_o, 32'h0000_0006);
        check("mis_no_req_after", {31'b0, bus_req_o}, 32'd0);
        check("mis_align_clear", {31'b0, align_err_o}, 32'd0);
        @(posedge clk);
        #1;

        // Timed-out read (TIMEOUT = 4).
        access("to0", 1, 0, 32'h0000_0020, 32'h0, -1, 32'h0, 0, 5, 4, dx);
        check("to0_badaddr", badaddr_o, 32'h0000_0020);
        check("to0_rdata", rdata_o, 32'h0);

        // Both strobes: a write; stray acks in DONE and the following IDLE.
        access("both", 1, 1, 32'h0000_0040, 32'hA5A5_A5A5, 0, 32'h0, 1, 2, 1, dx);
        bus_ack_i = 1'b1;
        @(negedge clk);
        check("stray_idle_req", {31'b0, bus_req_o}, 32'd0);
        check("stray_idle_stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk);
        #1;
        check("stray_after_req", {31'b0, bus_req_o}, 32'd0);
        check("stray_after_valid", {31'b0, rdata_valid_o}, 32'd0);
        check("stray_rdata", rdata_o, 32'h0);
        bus_ack_i = 1'b0;

        // Back-to-back loads complete three cycles apart.
        access("bb0", 1, 0, 32'h0000_0100, 32'h0, 0, 32'h1111_1111, 0, 2, 1, d1);
        access("bb1", 1, 0, 32'h0000_0104, 32'h0, 0, 32'h2222_2222, 0, 2, 1, d2);
        check("bb_spacing", d2 - d1, 32'd3);

        // Reset in the second BUSY cycle.
        mem_rd_i = 1'b1;
        addr_i = 32'h0000_0080;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_busy1", {31'b0, bus_req_o}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        mem_rd_i = 1'b0;
        #1;
        check("rst_mid_req_drop", {31'b0, bus_req_o}, 32'd0);
        check("rst_mid_stall_drop", {31'b0, stall_o}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_post_req", {31'b0, bus_req_o}, 32'd0);
        check("rst_post_stall", {31'b0, stall_o}, 32'd0);
        check("rst_post_pulses", {29'b0, rdata_valid_o, timeout_o, align_err_o}, 32'd0);
        check("rst_post_rdata", rdata_o, 32'd0);
        check("rst_post_badaddr", badaddr_o, 32'd0);
        check("rst_post_bus", bus_addr_o | bus_wdata_o | {31'b0, bus_we_o}, 32'd0);
        @(negedge clk);
        check("rst_post_idle_req", {31'b0, bus_req_o}, 32'd0);

        check("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
